// File: rtl/audipus_spi_pkg.sv
// Shared types and constants for the SPI register-access initiator.
package audipus_spi_pkg;

  localparam int unsigned DEF_ADDR_BITS = 7;
  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned FRAME_BITS    = 1 + DEF_ADDR_BITS + DEF_DATA_BITS;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftLo,
    StShiftHi,
    StHold,
    StGap
  } state_e;

  function automatic int unsigned frame_bits(input int unsigned addr_bits,
                                             input int unsigned data_bits);
    return 1 + addr_bits + data_bits;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter: strobes phase_end_o every CLK_DIV enabled cycles, first_o on the
// first cycle of each half-period. Held at zero while clr_i is high.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic first_o,
  output logic phase_end_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign first_o     = en_i && (cnt_q == '0);
  assign phase_end_o = en_i && (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = phase_end_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI initiator issuing one {rw, addr, data} register frame per start request.
// Define SPI_MASTER_MISO_SYNC_EN to add a 2-flop MISO synchronizer (needs CLK_DIV >= 3).
module spi_master_ctrl
  import audipus_spi_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned CS_HOLD   = 2,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 rw_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 spi_cs_o,
  output logic                 spi_clk_o,
  output logic                 spi_mosi_o,
  input  logic                 spi_miso_i
);

  localparam int unsigned FrameBits = frame_bits(ADDR_BITS, DATA_BITS);
  localparam int unsigned BitCntW   = $clog2(FrameBits);
  localparam int unsigned WaitW     = 8;

  state_e               state_q;
  logic [FrameBits-2:0] tx_sr_q;
  logic [DATA_BITS-1:0] rx_sr_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [WaitW-1:0]     wait_q, wait_last;
  logic                 rw_q;
  logic                 shifting, first_hi, phase_end, sample_en, miso_s, wait_done;

  assign shifting = (state_q == StShiftHi) || (state_q == StShiftLo);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (shifting),
    .clr_i      (!shifting),
    .first_o    (first_hi),
    .phase_end_o(phase_end)
  );

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) miso_sync_q <= '0;
    else       miso_sync_q <= {miso_sync_q[0], spi_miso_i};
  end

  // Sampling late in the high phase absorbs the synchronizer latency.
  assign miso_s    = miso_sync_q[1];
  assign sample_en = (state_q == StShiftHi) && phase_end;
  logic unused_first;
  assign unused_first = first_hi;
`else
  assign miso_s    = spi_miso_i;
  assign sample_en = (state_q == StShiftHi) && first_hi;
`endif

  always_comb begin
    wait_last = WaitW'(CS_GAP - 1);
    if (state_q == StSetup)     wait_last = WaitW'(CS_SETUP - 1);
    else if (state_q == StHold) wait_last = WaitW'(CS_HOLD - 1);
  end
  assign wait_done = (wait_q == wait_last);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      wait_q     <= '0;
      rw_q       <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rdata_o    <= '0;
      spi_cs_o   <= 1'b0;
      spi_clk_o  <= 1'b0;
      spi_mosi_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (sample_en) rx_sr_q <= {rx_sr_q[DATA_BITS-2:0], miso_s};
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            tx_sr_q    <= {addr_i, wdata_i};
            rw_q       <= rw_i;
            spi_mosi_o <= rw_i;
            spi_cs_o   <= 1'b1;
            busy_o     <= 1'b1;
            bit_cnt_q  <= '0;
            wait_q     <= '0;
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          if (wait_done) begin
            spi_clk_o <= 1'b1;
            state_q   <= StShiftHi;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StShiftHi: begin
          if (phase_end) begin
            spi_clk_o <= 1'b0;
            if (bit_cnt_q == BitCntW'(FrameBits - 1)) begin
              wait_q  <= '0;
              state_q <= StHold;
            end else begin
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              spi_mosi_o <= tx_sr_q[FrameBits-2];
              tx_sr_q    <= tx_sr_q << 1;
              state_q    <= StShiftLo;
            end
          end
        end
        StShiftLo: begin
          if (phase_end) begin
            spi_clk_o <= 1'b1;
            state_q   <= StShiftHi;
          end
        end
        StHold: begin
          if (wait_done) begin
            spi_cs_o <= 1'b0;
            done_o   <= 1'b1;
            if (rw_q == RW_READ) rdata_o <= rx_sr_q;
            wait_q   <= '0;
            state_q  <= StGap;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StGap: begin
          if (wait_done) begin
            busy_o     <= 1'b0;
            spi_mosi_o <= 1'b0;
            state_q    <= StIdle;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed and randomized register transactions against a behavioural SPI slave model.
module tb_spi_master_ctrl;
  import audipus_spi_pkg::*;

  localparam int unsigned AB  = 7;
  localparam int unsigned DB  = 8;
  localparam int unsigned CD  = 4;
  localparam int unsigned CSS = 2;
  localparam int unsigned CSH = 2;
  localparam int unsigned CSG = 2;
  localparam int unsigned FB  = 1 + AB + DB;
  localparam int CsHigh = CSS + (2 * FB - 1) * CD + CSH;
  localparam int Budget = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rw = 1'b0;
  logic [AB-1:0] addr = '0;
  logic [DB-1:0] wdata = '0;
  logic          busy, done, cs, sclk, mosi;
  logic [DB-1:0] rdata;
  logic          miso = 1'b0;

  spi_master_ctrl #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .CLK_DIV(CD),
    .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_GAP(CSG)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .rw_i      (rw),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .busy_o    (busy),
    .done_o    (done),
    .rdata_o   (rdata),
    .spi_cs_o  (cs),
    .spi_clk_o (sclk),
    .spi_mosi_o(mosi),
    .spi_miso_i(miso)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Slave model and bus monitor, sampled on the falling system clock edge.
  logic          clr_mon = 1'b0;
  logic [FB-1:0] mword = '0;
  int            cyc, cs_cyc, busy_cyc, done_cnt, rise_cnt, cs_rise_cnt;
  int            cs_rise_cyc, first_clk_cyc, done_cyc;
  logic          done_cs_ok;
  logic [63:0]   mosi_word;
  logic          prev_cs, prev_clk;
  logic [DB-1:0] exp_rdata = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr_mon) begin
      cs_cyc      <= 0;
      busy_cyc    <= 0;
      done_cnt    <= 0;
      rise_cnt    <= 0;
      cs_rise_cnt <= 0;
      done_cs_ok  <= 1'b1;
      mosi_word   <= '0;
    end else begin
      if (cs) cs_cyc <= cs_cyc + 1;
      if (busy) busy_cyc <= busy_cyc + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        if (cs || !prev_cs) done_cs_ok <= 1'b0;
      end
      if (cs && !prev_cs) begin
        cs_rise_cnt <= cs_rise_cnt + 1;
        cs_rise_cyc <= cyc;
        miso        <= mword[FB-1];
      end
      if (sclk && !prev_clk) begin
        rise_cnt  <= rise_cnt + 1;
        mosi_word <= {mosi_word[62:0], mosi};
        if (rise_cnt == 0) first_clk_cyc <= cyc;
      end
      if (!sclk && prev_clk && rise_cnt < int'(FB)) miso <= mword[int'(FB) - 1 - rise_cnt];
    end
    prev_cs  <= cs;
    prev_clk <= sclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk);
    #1 clr_mon = 1'b1;
    @(negedge clk);
    #1 clr_mon = 1'b0;
  endtask

  task automatic wait_done_cnt(input int n, input string tag);
    int k = 0;
    while (done_cnt < n && k < Budget) begin
      @(negedge clk);
      #1 k++;
    end
    check(tag, 64'(done_cnt >= n), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < Budget) begin
      @(negedge clk);
      #1 k++;
    end
    check(tag, 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    #2;
  endtask

  task automatic run_txn(input logic r, input logic [AB-1:0] a, input logic [DB-1:0] wd,
                         input logic [DB-1:0] md, input bit extra_start, input string tag);
    logic [FB-1:0] frame;
    frame = {r, a, wd};
    mword = {(FB - DB)'($urandom), md};
    clear_mon();
    @(negedge clk);
    start = 1'b1; rw = r; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0; rw = 1'($urandom); addr = AB'($urandom); wdata = DB'($urandom);
    if (extra_start) begin
      repeat (9) @(negedge clk);
      start = 1'b1; rw = ~r; addr = ~a; wdata = ~wd;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done_cnt(1, {tag, "_done_seen"});
    wait_idle({tag, "_idle"});
    if (r == RW_READ) exp_rdata = md;
    check({tag, "_mosi"}, 64'(mosi_word[FB-1:0]), 64'(frame));
    check({tag, "_rises"}, 64'(rise_cnt), 64'(FB));
    check({tag, "_cs_high"}, 64'(cs_cyc), 64'(CsHigh));
    check({tag, "_busy_len"}, 64'(busy_cyc), 64'(CsHigh + int'(CSG)));
    check({tag, "_setup"}, 64'(first_clk_cyc - cs_rise_cyc), 64'(CSS));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_at_cs_fall"}, 64'(done_cs_ok), 64'd1);
    check({tag, "_cs_rises"}, 64'(cs_rise_cnt), 64'd1);
    check({tag, "_rdata"}, 64'(rdata), 64'(exp_rdata));
  endtask

  initial begin
    logic [FB-1:0] bb_frame;
    int k;

    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_cs", 64'(cs), 64'd0);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(RW_WRITE, 7'h12, 8'hA5, 8'h3C, 1'b0, "wr12");
    run_txn(RW_READ, 7'h05, 8'h00, 8'h55, 1'b0, "rd05");
    check("rd05_first8", 64'(mosi_word[FB-1 -: 8]), 64'h85);

    for (int i = 0; i < 6; i++) begin
      run_txn(1'($urandom), AB'($urandom), DB'($urandom), DB'($urandom), 1'b0, "rand");
    end

    run_txn(RW_WRITE, 7'h33, 8'h0F, 8'hFF, 1'b1, "ignored_start");

    // Abort mid-frame with an asynchronous reset after the 5th spi_clk rise.
    mword = '1;
    clear_mon();
    @(negedge clk);
    start = 1'b1; rw = RW_READ; addr = 7'h41; wdata = 8'h99;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (rise_cnt < 5 && k < Budget) begin
      @(negedge clk);
      #1 k++;
    end
    check("abort_reach_rise5", 64'(rise_cnt >= 5), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_cs", 64'(cs), 64'd0);
    check("abort_sclk", 64'(sclk), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0;
    repeat (CsHigh + 20) @(negedge clk);
    #2;
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_rdata", 64'(rdata), 64'd0);
    run_txn(RW_WRITE, 7'h2A, 8'hC7, 8'h00, 1'b0, "after_abort");
    run_txn(RW_READ, 7'h7F, 8'h00, 8'hC3, 1'b0, "rdC3");

    // start held high across two frames.
    bb_frame = {RW_WRITE, 7'h5A, 8'h3E};
    mword = '0;
    clear_mon();
    @(negedge clk);
    start = 1'b1; rw = RW_WRITE; addr = 7'h5A; wdata = 8'h3E;
    wait_done_cnt(1, "b2b_first_done");
    k = 0;
    while (cs_rise_cnt < 2 && k < Budget) begin
      @(negedge clk);
      #1 k++;
    end
    check("b2b_second_cs", 64'(cs_rise_cnt), 64'd2);
    check("b2b_gap", 64'(cs_rise_cyc - done_cyc), 64'(CSG + 1));
    @(negedge clk);
    start = 1'b0;
    wait_done_cnt(2, "b2b_second_done");
    wait_idle("b2b_idle");
    check("b2b_mosi", 64'(mosi_word[2*FB-1:0]), 64'({bb_frame, bb_frame}));
    check("b2b_rises", 64'(rise_cnt), 64'(2 * FB));
    check("b2b_done_cnt", 64'(done_cnt), 64'd2);
    check("b2b_rdata", 64'(rdata), 64'(exp_rdata));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
